// File: rtl/systolic_drain.sv
// Snapshots a ROWSxCOLS array of PE results and drains it row-major over a
// valid/ready stream, one element per cycle when the sink is always ready.
module systolic_drain #(
  parameter int unsigned M_BW   = 16,
  parameter int unsigned ROWS   = 5,
  parameter int unsigned COLS   = 5,
  parameter int unsigned IDX_BW = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [M_BW*ROWS*COLS-1:0]  i_mul_result,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [M_BW-1:0]            o_data,
  output logic [IDX_BW-1:0]          o_row,
  output logic [IDX_BW-1:0]          o_col,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_BW-1:0] LAST_ROW = IDX_BW'(ROWS - 1);
  localparam logic [IDX_BW-1:0] LAST_COL = IDX_BW'(COLS - 1);

  state_t                      state, state_next;
  logic [M_BW*ROWS*COLS-1:0]   snap;
  logic [IDX_BW-1:0]           row, col;
  logic                        at_last;
  logic                        xfer;
  logic                        take;

  assign at_last = (row == LAST_ROW) && (col == LAST_COL);
  assign xfer    = (state == STREAM) && i_ready;
  assign take    = (state == IDLE) && i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_valid    = 1'b0;
    o_last     = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) state_next = STREAM;
      end
      STREAM: begin
        o_valid = 1'b1;
        o_last  = at_last;
        o_busy  = 1'b1;
        if (i_ready && at_last) state_next = DONE;
      end
      DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (take) begin
      snap <= i_mul_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (take) begin
      row <= '0;
      col <= '0;
    end else if (xfer && !at_last) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output mux reads only the snapshot and registered indices.
  always_comb begin
    o_data = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (row == IDX_BW'(r) && col == IDX_BW'(c)) begin
          o_data = snap[(c*ROWS + r)*M_BW +: M_BW];
        end
      end
    end
  end

  assign o_row = row;
  assign o_col = col;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: full drains under several ready
// patterns, snapshot isolation, ignored starts and mid-stream reset.
module tb_systolic_drain;

  localparam int unsigned M_BW   = 16;
  localparam int unsigned ROWS   = 5;
  localparam int unsigned COLS   = 5;
  localparam int unsigned IDX_BW = 3;
  localparam int          BEATS  = ROWS * COLS;

  logic                      clk;
  logic                      rst_n;
  logic                      i_start;
  logic [M_BW*ROWS*COLS-1:0] i_mul_result;
  logic                      i_ready;
  logic                      o_valid;
  logic [M_BW-1:0]           o_data;
  logic [IDX_BW-1:0]         o_row;
  logic [IDX_BW-1:0]         o_col;
  logic                      o_last;
  logic                      o_busy;
  logic                      o_done;

  int n_tests;
  int n_fail;

  systolic_drain #(
    .M_BW  (M_BW),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .IDX_BW(IDX_BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_mul_result(i_mul_result),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_row       (o_row),
    .o_col       (o_col),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        i_mul_result[(c*ROWS + r)*M_BW +: M_BW] = 16'(16'h0100 * r + c);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
    check({tag, "_done"},  32'(o_done),  32'd0);
    check({tag, "_last"},  32'(o_last),  32'd0);
  endtask

  // mode 0: ready=1; 1: ready 1,0,0 repeating; 2: stray starts at beat 10 and
  // last beat; 3: ready low 20 cycles first; 4: reset at beat 12; 5: bus
  // overwritten with FFFF after start.
  task automatic run_stream(input int mode);
    int  k;
    int  cyc;
    int  r;
    int  c;
    logic rdy;
    @(negedge clk);
    i_start = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    if (mode == 5) i_mul_result = '1;
    k   = 0;
    cyc = 0;
    while (k < BEATS && cyc < 200) begin
      r = k / COLS;
      c = k % COLS;
      check("beat_valid", 32'(o_valid), 32'd1);
      check("beat_row",   32'(o_row),   32'(r));
      check("beat_col",   32'(o_col),   32'(c));
      check("beat_data",  32'(o_data),  32'(16'h0100 * r + c));
      check("beat_last",  32'(o_last),  32'(k == BEATS - 1));
      check("beat_busy",  32'(o_busy),  32'd1);
      if (mode == 4 && k == 12) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_async");
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_row",  32'(o_row),  32'd0);
        check("rst_col",  32'(o_col),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check_idle_outputs("post_rst");
        end
        return;
      end
      case (mode)
        1:       rdy = (cyc % 3 == 0);
        3:       rdy = (cyc >= 20);
        default: rdy = 1'b1;
      endcase
      i_ready = rdy;
      i_start = (mode == 2) && (k == 10 || k == BEATS - 1);
      @(negedge clk);
      i_start = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    check("stream_bound", 32'(k), 32'(BEATS));
    check("done_pulse", 32'(o_done),  32'd1);
    check("done_valid", 32'(o_valid), 32'd0);
    check("done_busy",  32'(o_busy),  32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("after_done");
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_ready      = 1'b0;
    i_mul_result = '0;
    set_pattern();
    #12;
    check_idle_outputs("reset");
    check("reset_data", 32'(o_data), 32'd0);
    check("reset_row",  32'(o_row),  32'd0);
    check("reset_col",  32'(o_col),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run_stream(0);
    run_stream(1);
    run_stream(5);
    set_pattern();
    run_stream(2);
    run_stream(4);
    run_stream(0);
    run_stream(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 The module SHALL have parameter M_BW, default 16, the bit width of one PE accumulation result.
REQ-002 The module SHALL have parameter ROWS, default 5, the array row count (2..8).
REQ-003 The module SHALL have parameter COLS, default 5, the array column count (2..8).
REQ-004 The module SHALL have parameter IDX_BW, default 3, the bit width of the row/column index outputs.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The module SHALL have port i_start, input, 1 bit: single-cycle request to snapshot and drain the array results.
REQ-008 The module SHALL have port i_mul_result, input, M_BW*ROWS*COLS bits: the array result bus; element (r,c) occupies bits [(c*ROWS+r)*M_BW +: M_BW] (column-major).
REQ-009 The module SHALL have port i_ready, input, 1 bit: downstream ready.
REQ-010 The module SHALL have port o_valid, output, 1 bit: o_data/o_row/o_col/o_last are valid.
REQ-011 The module SHALL have port o_data, output, M_BW bits: the current result element.
REQ-012 The module SHALL have ports o_row and o_col, outputs, IDX_BW bits each: the (r,c) index of o_data.
REQ-013 The module SHALL have port o_last, output, 1 bit: high with the element (ROWS-1,COLS-1).
REQ-014 The module SHALL have port o_busy, output, 1 bit: high in STREAM and DONE states.
REQ-015 The module SHALL have port o_done, output, 1 bit: one-cycle pulse after the last transfer.

Function
REQ-016 The FSM SHALL have states IDLE, STREAM and DONE, encoded as registered state.
REQ-017 In IDLE, i_start=1 SHALL register all ROWS*COLS elements of i_mul_result into a snapshot register, clear both indices to 0, and move to STREAM on the same edge.
REQ-018 The first o_valid SHALL appear in the cycle after the i_start cycle (1-cycle latency), carrying element (0,0).
REQ-019 o_data SHALL be the snapshot element at (o_row,o_col); later changes on i_mul_result SHALL NOT affect the stream.
REQ-020 Output order SHALL be row-major: (0,0),(0,1)..(0,COLS-1),(1,0)..(ROWS-1,COLS-1), exactly ROWS*COLS beats.
REQ-021 A transfer SHALL occur on an edge where o_valid=1 and i_ready=1; only then does the index advance (col+1, wrap to 0 with row+1 at COLS-1).
REQ-022 While o_valid=1 and i_ready=0, o_data, o_row, o_col and o_last SHALL hold stable and o_valid SHALL stay high.
REQ-023 o_valid SHALL be 1 in every STREAM cycle (no bubbles); back-to-back transfers SHALL sustain one element per cycle.
REQ-024 The transfer of the o_last element SHALL move the FSM to DONE; o_valid SHALL be 0 in DONE.
REQ-025 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-026 i_start SHALL be ignored in STREAM and DONE, including the cycle of the last transfer; no snapshot is taken.
REQ-027 o_valid, o_last and o_done SHALL be 0 in IDLE; o_busy SHALL be 0 only in IDLE.
REQ-028 o_data, o_row and o_col SHALL be purely derived from registered index and snapshot (no combinational path from i_ready or i_mul_result).

Reset
REQ-029 rst_n=0 SHALL asynchronously force state IDLE, indices 0, snapshot 0, and o_valid, o_last, o_busy, o_done, o_data, o_row, o_col all 0.
REQ-030 Reset asserted mid-STREAM SHALL abort the drain; after release no further beats SHALL be emitted until a new i_start.

Verification
REQ-031 Element (r,c) = 16'h0100*r + c, i_ready=1, i_start pulse -> 25 consecutive beats from next cycle, values 0000,0001..0404 row-major, o_last on beat 25, o_done one cycle later.
REQ-032 i_ready toggled 1,0,0,1,... during stream -> o_data/o_row/o_col stable across stalled cycles; no element duplicated or skipped.
REQ-033 i_mul_result changed to all 16'hFFFF the cycle after i_start -> stream still carries the snapshot values.
REQ-034 i_start pulsed during beat 10 and on the last-transfer cycle -> ignored; exactly 25 beats, one o_done.
REQ-035 rst_n pulsed low at beat 12 -> all outputs 0 immediately; no o_valid after release until new i_start, which then restarts at (0,0).
REQ-036 i_ready=0 held for 20 cycles on beat (0,0) -> o_valid stays 1 with data 0000; completion proceeds normally after i_ready=1.
